decoded_instr_queue: RTL and testbench

- Small FIFO between the decode stage and the reorder/issue logic.
- Buffers decoded scoreboard entries with their control-flow flag, decoupling decode from issue back-pressure.
- Exposes the head entry plus one lookahead entry, so the downstream reorder stage can inspect two consecutive instructions, e.g. adjacent load/store pairs.

---
 rtl/decoded_instr_queue_pkg.sv | 35 +++
 rtl/decoded_instr_queue.sv | 108 ++++++++++
 tb/tb_decoded_instr_queue.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/decoded_instr_queue_pkg.sv
// Shared decode/issue types: scoreboard entry layout, functional-unit encoding
// and the memory-op classifier used by the decoded queue and the reorder stage.
package decoded_instr_queue_pkg;

    localparam int DECODED_QUEUE_DEPTH = 4;

    typedef enum logic [3:0] {
        NONE      = 4'd0,
        LOAD      = 4'd1,
        STORE     = 4'd2,
        ALU       = 4'd3,
        CTRL_FLOW = 4'd4,
        MULT      = 4'd5,
        CSR       = 4'd6
    } fu_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  trans_id;
        fu_t         fu;
        logic [6:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] result;
        logic        valid;
    } scoreboard_entry_t;

    localparam int SBE_W = $bits(scoreboard_entry_t);

    function automatic logic is_mem_op(fu_t fu);
        return (fu == LOAD) || (fu == STORE);
    endfunction

endpackage

// File: rtl/decoded_instr_queue.sv
// FIFO between decode and reorder/issue. Presents the head entry plus one
// lookahead entry so the reorder stage can pair adjacent memory ops.
module decoded_instr_queue
    import decoded_instr_queue_pkg::*;
#(
    parameter  int DEPTH = DECODED_QUEUE_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic [SBE_W-1:0] decoded_entry_i,
    input  logic             decoded_valid_i,
    input  logic             is_ctrl_flow_i,
    output logic             decoded_ack_o,
    output logic [SBE_W-1:0] issue_entry_o,
    output logic             issue_entry_valid_o,
    output logic             is_ctrl_flow_o,
    input  logic             issue_instr_ack_i,
    output logic [SBE_W-1:0] next_entry_o,
    output logic             next_valid_o,
    output logic             next_is_ctrl_flow_o,
    output logic             head_is_mem_o,
    output logic             next_is_mem_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    scoreboard_entry_t mem_sbe [0:DEPTH-1];
    logic              mem_cf  [0:DEPTH-1];

    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] next_ptr;
    logic [CNT_W-1:0] count;

    logic              push;
    logic              pop;
    logic              head_valid;
    logic              next_valid;
    scoreboard_entry_t head_sbe;
    scoreboard_entry_t next_sbe;

    assign head_valid = (count != '0);
    assign next_valid = (count >= CNT_W'(2));
    assign next_ptr   = rptr + PTR_W'(1);

    // Full refuses pushes even when a pop happens this cycle: no full-through.
    assign push = decoded_valid_i & (count < FULL_CNT) & ~flush_i;
    assign pop  = issue_instr_ack_i & head_valid & ~flush_i;

    assign head_sbe = head_valid ? mem_sbe[rptr]     : '0;
    assign next_sbe = next_valid ? mem_sbe[next_ptr] : '0;

    assign decoded_ack_o       = push & rst_ni;
    assign issue_entry_o       = head_sbe;
    assign issue_entry_valid_o = head_valid;
    assign is_ctrl_flow_o      = head_valid & mem_cf[rptr];
    assign next_entry_o        = next_sbe;
    assign next_valid_o        = next_valid;
    assign next_is_ctrl_flow_o = next_valid & mem_cf[next_ptr];
    assign head_is_mem_o       = head_valid & is_mem_op(head_sbe.fu);
    assign next_is_mem_o       = next_valid & is_mem_op(next_sbe.fu);
    assign count_o             = count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (flush_i) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= next_ptr;
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Payload storage is never reset; validity comes solely from count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_sbe[wptr] <= decoded_entry_i;
            mem_cf[wptr]  <= is_ctrl_flow_i;
        end
    end

`ifndef SYNTHESIS
    assert property (@(posedge clk_i) disable iff (!rst_ni) count <= FULL_CNT);
    assert property (@(posedge clk_i) disable iff (!rst_ni)
                     (wptr - rptr) == count[PTR_W-1:0]);
    assert property (@(posedge clk_i) disable iff (!rst_ni)
                     !(push && (count == FULL_CNT)));
`endif

endmodule

// File: tb/tb_decoded_instr_queue.sv
// Scoreboard bench for decoded_instr_queue: accepted entries are queued in
// order and compared against the head whenever the consumer takes it.
module tb_decoded_instr_queue;
    import decoded_instr_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        scoreboard_entry_t sbe;
        logic              cf;
    } exp_t;

    logic             clk_i;
    logic             rst_ni;
    logic             flush_i;
    logic [SBE_W-1:0] decoded_entry_i;
    logic             decoded_valid_i;
    logic             is_ctrl_flow_i;
    logic             decoded_ack_o;
    logic [SBE_W-1:0] issue_entry_o;
    logic             issue_entry_valid_o;
    logic             is_ctrl_flow_o;
    logic             issue_instr_ack_i;
    logic [SBE_W-1:0] next_entry_o;
    logic             next_valid_o;
    logic             next_is_ctrl_flow_o;
    logic             head_is_mem_o;
    logic             next_is_mem_o;
    logic [CNT_W-1:0] count_o;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    decoded_instr_queue #(.DEPTH(DEPTH)) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .flush_i             (flush_i),
        .decoded_entry_i     (decoded_entry_i),
        .decoded_valid_i     (decoded_valid_i),
        .is_ctrl_flow_i      (is_ctrl_flow_i),
        .decoded_ack_o       (decoded_ack_o),
        .issue_entry_o       (issue_entry_o),
        .issue_entry_valid_o (issue_entry_valid_o),
        .is_ctrl_flow_o      (is_ctrl_flow_o),
        .issue_instr_ack_i   (issue_instr_ack_i),
        .next_entry_o        (next_entry_o),
        .next_valid_o        (next_valid_o),
        .next_is_ctrl_flow_o (next_is_ctrl_flow_o),
        .head_is_mem_o       (head_is_mem_o),
        .next_is_mem_o       (next_is_mem_o),
        .count_o             (count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic scoreboard_entry_t mk(input int id, input fu_t fu);
        scoreboard_entry_t e;
        e          = '0;
        e.pc       = 32'h0000_1000 + 32'(id * 4);
        e.trans_id = 3'(id);
        e.fu       = fu;
        e.op       = 7'(id + 3);
        e.rd       = 5'(id + 1);
        e.result   = 32'hA500_0000 | 32'(id);
        e.valid    = 1'b1;
        return e;
    endfunction

    // One clock of stimulus; the scoreboard predicts ack, pops and count.
    task automatic drive(input logic pv, input scoreboard_entry_t e, input logic cf,
                         input logic pa, input logic fl, input string name);
        logic exp_ack;
        exp_t exp;
        decoded_valid_i   = pv;
        decoded_entry_i   = e;
        is_ctrl_flow_i    = cf;
        issue_instr_ack_i = pa;
        flush_i           = fl;
        #1;
        exp_ack = pv && !fl && (exp_q.size() < DEPTH);
        checks++;
        if (decoded_ack_o !== exp_ack) begin
            errors++;
            $display("FAIL %s ack: got %b expected %b", name, decoded_ack_o, exp_ack);
        end
        if (pa && !fl && exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            checks++;
            if (issue_entry_o !== exp.sbe || is_ctrl_flow_o !== exp.cf || issue_entry_valid_o !== 1'b1) begin
                errors++;
                $display("FAIL %s pop: got %h/%b/v%b expected %h/%b/v1", name,
                         issue_entry_o, is_ctrl_flow_o, issue_entry_valid_o, exp.sbe, exp.cf);
            end
        end
        if (exp_ack) exp_q.push_back('{sbe: e, cf: cf});
        if (fl) exp_q.delete();
        @(posedge clk_i);
        #1;
        decoded_valid_i   = 1'b0;
        issue_instr_ack_i = 1'b0;
        flush_i           = 1'b0;
        is_ctrl_flow_i    = 1'b0;
        decoded_entry_i   = '0;
        checks++;
        if (count_o !== CNT_W'(exp_q.size())) begin
            errors++;
            $display("FAIL %s count: got %0d expected %0d", name, count_o, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_ni          = 1'b0;
        decoded_valid_i = 1'b1;
        decoded_entry_i = mk(9, LOAD);
        #12;
        checks++;
        if (decoded_ack_o !== 1'b0 || issue_entry_valid_o !== 1'b0 || next_valid_o !== 1'b0 ||
            count_o !== '0 || issue_entry_o !== '0 || next_entry_o !== '0) begin
            errors++;
            $display("FAIL reset_held: ack=%b v=%b nv=%b cnt=%0d head=%h next=%h expected all zero",
                     decoded_ack_o, issue_entry_valid_o, next_valid_o, count_o, issue_entry_o, next_entry_o);
        end
        decoded_valid_i = 1'b0;
        decoded_entry_i = '0;
        rst_ni          = 1'b1;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        checks++;
        if (count_o !== '0 || issue_entry_valid_o !== 1'b0 || decoded_ack_o !== 1'b0 ||
            next_valid_o !== 1'b0 || issue_entry_o !== '0 || next_entry_o !== '0 ||
            is_ctrl_flow_o !== 1'b0 || head_is_mem_o !== 1'b0 || next_is_mem_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: cnt=%0d v=%b ack=%b nv=%b head=%h next=%h expected all zero",
                     count_o, issue_entry_valid_o, decoded_ack_o, next_valid_o, issue_entry_o, next_entry_o);
        end
    endtask

    task automatic test_single_push();
        scoreboard_entry_t a;
        a = mk(1, LOAD);
        drive(1'b1, a, 1'b0, 1'b0, 1'b0, "single_push");
        checks++;
        if (issue_entry_valid_o !== 1'b1 || issue_entry_o !== a || head_is_mem_o !== 1'b1 ||
            next_valid_o !== 1'b0 || next_entry_o !== '0 || next_is_mem_o !== 1'b0) begin
            errors++;
            $display("FAIL single_head: v=%b head=%h mem=%b nv=%b expected v=1 head=%h mem=1 nv=0",
                     issue_entry_valid_o, issue_entry_o, head_is_mem_o, next_valid_o, a);
        end
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, "single_pop");
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, "empty_pop");
    endtask

    task automatic test_full();
        scoreboard_entry_t b;
        scoreboard_entry_t c;
        b = mk(2, STORE);
        c = mk(3, ALU);
        drive(1'b1, mk(1, LOAD), 1'b0, 1'b0, 1'b0, "fill_a");
        drive(1'b1, b, 1'b0, 1'b0, 1'b0, "fill_b");
        drive(1'b1, c, 1'b0, 1'b0, 1'b0, "fill_c");
        drive(1'b1, mk(4, CTRL_FLOW), 1'b1, 1'b0, 1'b0, "fill_d");
        drive(1'b1, mk(5, LOAD), 1'b0, 1'b0, 1'b0, "full_refuse");
        drive(1'b1, mk(5, LOAD), 1'b0, 1'b1, 1'b0, "full_pop_refuse");
        checks++;
        if (issue_entry_o !== b || next_entry_o !== c || next_valid_o !== 1'b1 ||
            head_is_mem_o !== 1'b1 || next_is_mem_o !== 1'b0) begin
            errors++;
            $display("FAIL full_after_pop: head=%h next=%h nv=%b hm=%b nm=%b expected head=%h next=%h nv=1 hm=1 nm=0",
                     issue_entry_o, next_entry_o, next_valid_o, head_is_mem_o, next_is_mem_o, b, c);
        end
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, "drain_b");
        checks++;
        if (next_is_ctrl_flow_o !== 1'b1 || is_ctrl_flow_o !== 1'b0) begin
            errors++;
            $display("FAIL next_cf: next_cf=%b head_cf=%b expected 1/0", next_is_ctrl_flow_o, is_ctrl_flow_o);
        end
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, "drain_c");
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, "drain_d");
    endtask

    task automatic test_back_to_back();
        drive(1'b1, mk(10, ALU), 1'b0, 1'b0, 1'b0, "stream_prime");
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, mk(11 + i, (i % 2 == 0) ? STORE : MULT), i[0], 1'b1, 1'b0, "stream");
            checks++;
            if (count_o !== CNT_W'(1) || issue_entry_o !== mk(11 + i, (i % 2 == 0) ? STORE : MULT)) begin
                errors++;
                $display("FAIL stream_%0d: cnt=%0d head=%h expected cnt=1 head=%h", i, count_o,
                         issue_entry_o, mk(11 + i, (i % 2 == 0) ? STORE : MULT));
            end
        end
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, "stream_drain");
    endtask

    task automatic test_flush();
        scoreboard_entry_t g;
        g = mk(30, STORE);
        drive(1'b1, mk(20, LOAD), 1'b0, 1'b0, 1'b0, "pre_flush_0");
        drive(1'b1, mk(21, ALU), 1'b1, 1'b0, 1'b0, "pre_flush_1");
        drive(1'b1, mk(22, STORE), 1'b0, 1'b0, 1'b0, "pre_flush_2");
        drive(1'b1, mk(23, LOAD), 1'b0, 1'b1, 1'b1, "flush");
        checks++;
        if (issue_entry_valid_o !== 1'b0 || next_valid_o !== 1'b0 || issue_entry_o !== '0 ||
            next_entry_o !== '0 || head_is_mem_o !== 1'b0 || next_is_mem_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_outputs: v=%b nv=%b head=%h next=%h expected zeros",
                     issue_entry_valid_o, next_valid_o, issue_entry_o, next_entry_o);
        end
        drive(1'b1, g, 1'b0, 1'b0, 1'b0, "post_flush_push");
        checks++;
        if (issue_entry_o !== g || next_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL post_flush_head: head=%h nv=%b expected %h nv=0", issue_entry_o, next_valid_o, g);
        end
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, "post_flush_pop");
    endtask

    task automatic test_async_reset();
        scoreboard_entry_t h;
        h = mk(40, LOAD);
        drive(1'b1, mk(35, STORE), 1'b0, 1'b0, 1'b0, "pre_rst_0");
        drive(1'b1, mk(36, LOAD), 1'b1, 1'b0, 1'b0, "pre_rst_1");
        #3;
        rst_ni = 1'b0;
        #1;
        exp_q.delete();
        checks++;
        if (count_o !== '0 || issue_entry_valid_o !== 1'b0 || next_valid_o !== 1'b0 ||
            issue_entry_o !== '0 || next_entry_o !== '0 || is_ctrl_flow_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: cnt=%0d v=%b nv=%b head=%h next=%h expected zeros",
                     count_o, issue_entry_valid_o, next_valid_o, issue_entry_o, next_entry_o);
        end
        @(posedge clk_i);
        #2;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        drive(1'b1, h, 1'b0, 1'b0, 1'b0, "post_rst_push");
        checks++;
        if (issue_entry_valid_o !== 1'b1 || issue_entry_o !== h || head_is_mem_o !== 1'b1) begin
            errors++;
            $display("FAIL post_rst_head: v=%b head=%h expected v=1 head=%h", issue_entry_valid_o, issue_entry_o, h);
        end
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, "post_rst_pop");
    endtask

    initial begin
        flush_i           = 1'b0;
        decoded_entry_i   = '0;
        decoded_valid_i   = 1'b0;
        is_ctrl_flow_i    = 1'b0;
        issue_instr_ack_i = 1'b0;
        test_reset();
        test_single_push();
        test_full();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
